simplez_bus_cpu: RTL and testbench

//   Parametrised Simplez core: same 8-op ISA, but memory and peripherals sit on an

---
 rtl/simplez_bus_cpu_pkg.sv | 41 ++++
 rtl/simplez_bus_cpu_alu.sv | 38 +++
 rtl/simplez_bus_cpu.sv | 200 ++++++++++++++++++++
 tb/tb_simplez_bus_cpu.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplez_bus_cpu_pkg.sv
// -----------------------------------------------------------------------------
// simplez_bus_cpu_pkg
//   Shared definitions for the bus-attached Simplez core: default data width,
//   opcode (CO) and extended opcode (COE) constants, FSM state encoding and
//   ALU operation selector.
// -----------------------------------------------------------------------------
package simplez_bus_cpu_pkg;

  localparam int DW_DEFAULT = 12;

  // 3-bit major opcodes (top bits of the instruction word)
  localparam logic [2:0] CO_ST  = 3'd0;
  localparam logic [2:0] CO_LD  = 3'd1;
  localparam logic [2:0] CO_ADD = 3'd2;
  localparam logic [2:0] CO_BR  = 3'd3;
  localparam logic [2:0] CO_BZ  = 3'd4;
  localparam logic [2:0] CO_CLR = 3'd5;
  localparam logic [2:0] CO_DEC = 3'd6;
  localparam logic [2:0] CO_EXT = 3'd7;

  // 4-bit extended opcodes, only meaningful when CO == CO_EXT
  localparam logic [3:0] COE_HALT = 4'hE;
  localparam logic [3:0] COE_WAIT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALTED,
    S_WAITING
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_CLR,
    ALU_ADD,
    ALU_DEC
  } alu_op_t;

endpackage

// File: rtl/simplez_bus_cpu_alu.sv
// -----------------------------------------------------------------------------
// simplez_bus_cpu_alu
//   Combinational accumulator ALU. Arithmetic wraps modulo 2^DW, no carry.
// Ports
//   i_op      ALU operation (alu_op_t encoding): PASS b, CLR, ADD a+b, DEC a-1
//   i_a       accumulator operand
//   i_b       memory operand
//   o_result  new accumulator value
//   o_zero    1 when o_result is zero
// -----------------------------------------------------------------------------
module simplez_bus_cpu_alu
  import simplez_bus_cpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [1:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_result,
  output logic          o_zero
);

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    o_result = i_b;
    case (alu_op_t'(i_op))
      ALU_PASS: o_result = i_b;
      ALU_CLR:  o_result = '0;
      ALU_ADD:  o_result = i_a + i_b;
      ALU_DEC:  o_result = i_a - DW'(1);
      default:  o_result = i_b;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/simplez_bus_cpu.sv
// -----------------------------------------------------------------------------
// simplez_bus_cpu
//   Simplez CPU tile with memory and I/O on an external req/ack bus that may
//   insert any number of wait states. Instruction = {CO[2:0], CD[AW-1:0]}.
//   Build option: define SIMPLEZ_WAIT_EN to make COE 0xF a WAIT-for-tic
//   instruction; otherwise COE 0xF behaves as HALT and tic is ignored.
// Parameters
//   DW        data/instruction width (>= 6); AW = DW-3 is the address width
//   RESET_PC  program counter value loaded on reset
// Ports
//   clk, rstn   clock and synchronous active-low reset
//   mem_req     bus request, held until a cycle with mem_ack=1
//   mem_we      1 = write (ST), 0 = read
//   mem_addr    PC during instruction fetch, CD during data access
//   mem_wdata   write data (accumulator)
//   mem_rdata   read data, sampled when mem_ack=1
//   mem_ack     transfer complete, ignored unless a request is pending
//   tic         timer pulse that releases WAIT
//   acc, pc     accumulator and program counter (debug)
//   stop        high once HALT has executed
// -----------------------------------------------------------------------------
module simplez_bus_cpu
  import simplez_bus_cpu_pkg::*;
#(
  parameter  int DW       = DW_DEFAULT,
  parameter  int RESET_PC = 0,
  localparam int AW       = DW - 3
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic          tic,
  output logic [DW-1:0] acc,
  output logic [AW-1:0] pc,
  output logic          stop
);

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_acc;
  logic          r_z;
  logic          r_stop;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic [2:0]    w_co;
  logic [AW-1:0] w_cd;
  logic          w_is_wait;
  logic [1:0]    w_alu_op;
  logic [DW-1:0] w_alu_result;
  logic          w_alu_zero;

  assign w_co = r_ir[DW-1 -: 3];
  assign w_cd = r_ir[AW-1:0];

`ifdef SIMPLEZ_WAIT_EN
  assign w_is_wait = (r_ir[DW-1 -: 4] == COE_WAIT);
`else
  assign w_is_wait = 1'b0;
`endif

  // The ALU op depends on the opcode only; the FSM consumes the result solely
  // in the state where that opcode writes the accumulator.
  always_comb begin
    w_alu_op = ALU_PASS;
    case (w_co)
      CO_CLR:  w_alu_op = ALU_CLR;
      CO_DEC:  w_alu_op = ALU_DEC;
      CO_ADD:  w_alu_op = ALU_ADD;
      default: w_alu_op = ALU_PASS;
    endcase
  end

  simplez_bus_cpu_alu #(.DW(DW)) u_alu (
    .i_op     (w_alu_op),
    .i_a      (r_acc),
    .i_b      (mem_rdata),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  // Bus outputs are registered: they are set up on the edge that enters
  // FETCH/MEM and held untouched until the ack edge, which keeps them stable
  // across wait states.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and later assignments in the block override defaults.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_pc    <= AW'(RESET_PC);
      r_ir    <= '0;
      r_acc   <= '0;
      r_z     <= 1'b0;
      r_stop  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= r_pc;
          r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + AW'(1);
            r_req   <= 1'b0;
            r_state <= S_EXEC;
          end
        end

        S_EXEC: begin
          // Default: start fetching the next sequential instruction.
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= r_pc;
          case (w_co)
            CO_ST, CO_LD, CO_ADD: begin
              r_state <= S_MEM;
              r_addr  <= w_cd;
              r_we    <= (w_co == CO_ST);
              r_wdata <= r_acc;
            end
            CO_BR: begin
              r_pc   <= w_cd;
              r_addr <= w_cd;
            end
            CO_BZ: begin
              if (r_z) begin
                r_pc   <= w_cd;
                r_addr <= w_cd;
              end
            end
            CO_CLR, CO_DEC: begin
              r_acc <= w_alu_result;
              r_z   <= w_alu_zero;
            end
            default: begin
              r_req <= 1'b0;
              if (w_is_wait) begin
                r_state <= S_WAITING;
              end else begin
                r_state <= S_HALTED;
                r_stop  <= 1'b1;
              end
            end
          endcase
        end

        S_MEM: begin
          if (mem_ack) begin
            if (w_co != CO_ST) begin
              r_acc <= w_alu_result;
              r_z   <= w_alu_zero;
            end
            // Request stays asserted: next cycle is the following fetch.
            r_we    <= 1'b0;
            r_addr  <= r_pc;
            r_state <= S_FETCH;
          end
        end

        S_WAITING: begin
          if (tic) begin
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            r_state <= S_FETCH;
          end
        end

        S_HALTED: r_state <= S_HALTED;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign acc       = r_acc;
  assign pc        = r_pc;
  assign stop      = r_stop;

endmodule

// File: tb/tb_simplez_bus_cpu.sv
// -----------------------------------------------------------------------------
// tb_simplez_bus_cpu
//   Self-checking bench for simplez_bus_cpu (DW=12, AW=9). A bus slave with
//   random wait states serves a 512-word memory; an instruction-level
//   interpreter predicts every bus transfer plus final acc/pc/memory.
// -----------------------------------------------------------------------------
module tb_simplez_bus_cpu;

  localparam int DW  = 12;
  localparam int AW  = 9;
  localparam int MSZ = 512;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          tic = 1'b0;
  logic [DW-1:0] acc;
  logic [AW-1:0] pc;
  logic          stop;

  always #5 clk = ~clk;

  simplez_bus_cpu #(.DW(DW), .RESET_PC(0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .tic       (tic),
    .acc       (acc),
    .pc        (pc),
    .stop      (stop)
  );

  typedef struct {
    bit we;
    int addr;
    int wdata;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] mem       [MSZ];
  logic [DW-1:0] model_mem [MSZ];
  int            exp_acc;
  int            exp_pc;

  int n_checks = 0;
  int n_errors = 0;

  bit slave_en    = 1'b0;
  bit tic_rand_en = 1'b1;
  int delay_lo = 0, delay_hi = 0, wait_cnt = 0, cur_delay = 0, n_served = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-level reference: walks the program, queues the expected bus
  // transfers and leaves the final architectural state.
  task automatic model_run();
    int  p = 0, a = 0, steps = 0, ir, co, cd;
    bit  z = 1'b0, done = 1'b0;
    exp_q.delete();
    foreach (mem[i]) model_mem[i] = mem[i];
    while (!done && steps < 4000) begin
      exp_q.push_back('{we: 1'b0, addr: p, wdata: 0});
      ir = int'(model_mem[p]);
      p  = (p + 1) % MSZ;
      co = ir / 512;
      cd = ir % 512;
      steps++;
      case (co)
        0: begin exp_q.push_back('{we: 1'b1, addr: cd, wdata: a}); model_mem[cd] = 12'(a); end
        1: begin exp_q.push_back('{we: 1'b0, addr: cd, wdata: 0}); a = int'(model_mem[cd]); z = (a == 0); end
        2: begin
          exp_q.push_back('{we: 1'b0, addr: cd, wdata: 0});
          a = (a + int'(model_mem[cd])) % 4096;
          z = (a == 0);
        end
        3: p = cd;
        4: if (z) p = cd;
        5: begin a = 0; z = 1'b1; end
        6: begin a = (a + 4095) % 4096; z = (a == 0); end
        default: begin
          done = 1'b1;
`ifdef SIMPLEZ_WAIT_EN
          if (ir / 256 == 15) done = 1'b0;
`endif
        end
      endcase
    end
    exp_acc = a;
    exp_pc  = p;
  endtask

  // Bus slave: checks every request cycle (including wait states) against the
  // next expected transfer, acks after a random delay.
  initial forever begin
    @(negedge clk);
    if (slave_en) begin
      mem_ack   = 1'b0;
      mem_rdata = 12'($urandom);
      if (rstn && mem_req) begin
        if (exp_q.size() == 0) begin
          check("bus_extra_req", {23'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          check("bus_we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
          check("bus_addr", {23'd0, mem_addr}, exp_q[0].addr);
          if (exp_q[0].we) check("bus_wdata", {20'd0, mem_wdata}, exp_q[0].wdata);
        end
        if (wait_cnt >= cur_delay) begin
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          mem_ack   = 1'b1;
          n_served++;
          wait_cnt  = 0;
          cur_delay = $urandom_range(delay_hi, delay_lo);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (tic_rand_en) tic = ($urandom_range(29, 0) == 0);
  end

  task automatic do_reset();
    rstn     = 1'b0;
    slave_en = 1'b0;
    mem_ack  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_run(input int lo, input int hi);
    model_run();
    delay_lo  = lo;
    delay_hi  = hi;
    wait_cnt  = 0;
    cur_delay = $urandom_range(hi, lo);
    n_served  = 0;
    slave_en  = 1'b1;
    rstn      = 1'b1;
  endtask

  task automatic wait_served(input int n);
    int cyc = 0;
    while (n_served < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("served_timeout", (n_served >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic finish_run(input string tag);
    int cyc = 0, mism = 0;
    while (stop !== 1'b1 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_stop"}, {31'd0, stop}, 32'd1);
    @(negedge clk);
    check({tag, "_acc"}, {20'd0, acc}, exp_acc);
    check({tag, "_pc"}, {23'd0, pc}, exp_pc);
    check({tag, "_txn_left"}, exp_q.size(), 0);
    foreach (mem[i]) if (mem[i] !== model_mem[i]) mism++;
    check({tag, "_mem"}, mism, 0);
  endtask

  task automatic gen_prog();
    int len = 24, op;
    foreach (mem[i]) mem[i] = ($urandom_range(3, 0) == 0) ? 12'h000 : 12'($urandom);
    for (int i = 0; i < len - 1; i++) begin
      op = $urandom_range(27, 0);
      op = (op < 26) ? op % 7 : 7;
      case (op)
        0, 1, 2: mem[i] = 12'(op * 512 + int'($urandom_range(511, 256)));
        3, 4:    mem[i] = 12'(op * 512 + int'($urandom_range(len - 1, i + 1)));
        5, 6:    mem[i] = 12'(op * 512 + int'($urandom_range(511, 0)));
        default: mem[i] = ($urandom_range(1, 0) == 0) ? 12'hE00 : 12'hF00;
      endcase
    end
    mem[len-1] = 12'hE00;
  endtask

  initial begin
    int cnt, pc0;

    // Reset state, then LD/ADD/ST/HALT with 3 wait states per transfer
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 12'h20A; mem[1] = 12'h40B; mem[2] = 12'h00C; mem[3] = 12'hE00;
    mem[10] = 12'd5;  mem[11] = 12'd7;
    do_reset();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_acc", {20'd0, acc}, 32'd0);
    check("rst_stop", {31'd0, stop}, 32'd0);
    check("rst_pc", {23'd0, pc}, 32'd0);
    start_run(3, 3);
    @(negedge clk);
    check("first_fetch_req", {31'd0, mem_req}, 32'd1);
    check("first_fetch_addr", {23'd0, mem_addr}, 32'd0);
    finish_run("ldaddst");
    check("ldaddst_mem12", {20'd0, mem[12]}, 32'd12);
    check("ldaddst_acc12", {20'd0, acc}, 32'd12);

    // CLR, DEC, BZ not taken, CLR, BZ taken
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 12'hA00; mem[1] = 12'hC00; mem[2] = 12'h820;
    mem[3] = 12'hA00; mem[4] = 12'h820; mem[32] = 12'hE00;
    do_reset();
    start_run(0, 2);
    wait_served(3);
    check("dec_wrap", {20'd0, acc}, 32'hFFF);
    finish_run("bz");
    check("bz_pc", {23'd0, pc}, 32'h21);

    // HALT with zero-wait slave: bus stays idle and pc frozen
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 12'hE00;
    do_reset();
    start_run(0, 0);
    finish_run("halt");
    cnt = 0;
    pc0 = int'(pc);
    repeat (100) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || int'(pc) != pc0) cnt++;
    end
    check("halt_quiet", cnt, 0);
    check("halt_pc", {23'd0, pc}, 32'd1);

    // WAIT (or HALT when WAIT is not built in)
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 12'hF00; mem[1] = 12'hE00;
    tic_rand_en = 1'b0;
    tic = 1'b0;
    do_reset();
    start_run(0, 0);
    wait_served(1);
`ifdef SIMPLEZ_WAIT_EN
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (mem_req !== 1'b0) cnt++;
    end
    check("wait_noreq", cnt, 0);
    check("wait_nostop", {31'd0, stop}, 32'd0);
    tic = 1'b1;
    @(negedge clk);
    tic = 1'b0;
    check("wait_wake_req", {31'd0, mem_req}, 32'd1);
    check("wait_wake_addr", {23'd0, mem_addr}, 32'd1);
    finish_run("wait");
`else
    finish_run("wait_as_halt");
    check("wait_as_halt_pc", {23'd0, pc}, 32'd1);
`endif
    tic_rand_en = 1'b1;

    // Reset in the middle of a withheld LD transfer; late ack must be ignored
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 12'h20A; mem[10] = 12'd5;
    do_reset();
    start_run(0, 0);
    delay_lo = 1000;
    delay_hi = 1000;
    wait_served(1);
    repeat (3) @(negedge clk);
    slave_en = 1'b0;
    mem_ack  = 1'b0;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd1);
    check("midrst_mem_addr", {23'd0, mem_addr}, 32'd10);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_req_drop", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn      = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 12'h5A5;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_acc", {20'd0, acc}, 32'd0);
    check("midrst_refetch_addr", {23'd0, mem_addr}, 32'd0);

    // Random programs with random wait states
    for (int t = 0; t < 12; t++) begin
      gen_prog();
      do_reset();
      start_run(0, int'($urandom_range(4, 0)));
      finish_run("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
